// File: rtl/l1_inst_cache.sv
// Direct-mapped L1 instruction cache: 1-cycle registered lookup returning up to
// four instructions per hit, blocking miss handling, refill and natural line writes.
module l1_inst_cache #(
  parameter int addressWidth            = 64,
  parameter int cacheLineWith           = 512,
  parameter int instructionWidth        = 32,
  parameter int offsetWidth             = 6,
  parameter int indexWidth              = 8,
  parameter int tagWidth                = 50,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               fetchEnable_i,
  input  logic                               cacheReset_i,
  input  logic                               fetchStall_i,
  input  logic [PidSize-1:0]                 Pid_i,
  input  logic [TidSize-1:0]                 Tid_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic                               cacheUpdate_i,
  input  logic [addressWidth-1:0]            cacheUpdateAddress_i,
  input  logic [PidSize-1:0]                 cacheUpdatePid_i,
  input  logic [TidSize-1:0]                 cacheUpdateTid_i,
  input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
  input  logic [cacheLineWith-1:0]           cacheUpdateLine_i,
  input  logic                               naturalWriteEn_i,
  input  logic [addressWidth-1:0]            naturalWriteAddress_i,
  input  logic [cacheLineWith-1:0]           naturalWriteLine_i,
  input  logic [PidSize-1:0]                 naturalPid_i,
  input  logic [TidSize-1:0]                 naturalTid_i,
  output logic                               icachePCIncEnable_o,
  output logic [2:0]                         iCachePCIncVal_o,
  output logic                               outputEnable_o,
  output logic [4*instructionWidth-1:0]      outputBundle_o,
  output logic [addressWidth-1:0]            bundleAddress_o,
  output logic [1:0]                         bundleLen_o,
  output logic [PidSize-1:0]                 bundlePid_o,
  output logic [TidSize-1:0]                 bundleTid_o,
  output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
  output logic                               cacheMiss_o,
  output logic [addressWidth-1:0]            missedAddress_o,
  output logic [instructionCounterWidth-1:0] missedInstMajorId_o,
  output logic [PidSize-1:0]                 missedPid_o,
  output logic [TidSize-1:0]                 missedTid_o,
  output logic                               dbgState_o
);

  localparam int lineCount    = 1 << indexWidth;
  localparam int wordsPerLine = cacheLineWith / instructionWidth;
  localparam int wordBits     = $clog2(wordsPerLine);
  localparam int bundleSlots  = 4;

  // Handshakes: fetchEnable_i/cacheUpdate_i/naturalWriteEn_i are single-cycle
  // qualifiers with no back-pressure; outputEnable_o and cacheMiss_o are 1-cycle
  // valid pulses and the data fields beside them hold until the next pulse.
  typedef enum logic {IDLE = 1'b0, MISS_PENDING = 1'b1} state_t;
  state_t state_q, state_d;

  logic [lineCount-1:0]               valid_q;
  logic [tagWidth-1:0]                tag_mem  [lineCount];
  logic [PidSize-1:0]                 pid_mem  [lineCount];
  logic [TidSize-1:0]                 tid_mem  [lineCount];
  logic [cacheLineWith-1:0]           data_mem [lineCount];
  logic [instructionCounterWidth-1:0] maj_q;

  logic [tagWidth-1:0]   fetch_tag, upd_tag, nat_tag;
  logic [indexWidth-1:0] fetch_idx, upd_idx, nat_idx;
  logic [wordBits-1:0]   fetch_word;
  logic                  unused_offset_bits;

  assign fetch_tag  = fetchAddress_i[addressWidth-1 -: tagWidth];
  assign fetch_idx  = fetchAddress_i[offsetWidth +: indexWidth];
  assign fetch_word = fetchAddress_i[offsetWidth-1 -: wordBits];
  assign upd_tag    = cacheUpdateAddress_i[addressWidth-1 -: tagWidth];
  assign upd_idx    = cacheUpdateAddress_i[offsetWidth +: indexWidth];
  assign nat_tag    = naturalWriteAddress_i[addressWidth-1 -: tagWidth];
  assign nat_idx    = naturalWriteAddress_i[offsetWidth +: indexWidth];
  assign unused_offset_bits = ^{cacheUpdateAddress_i[offsetWidth-1:0],
                                naturalWriteAddress_i[offsetWidth-1:0]};

  logic do_lookup, fetch_hit;
  assign do_lookup = (state_q == IDLE) && fetchEnable_i && !fetchStall_i && !cacheReset_i;
  assign fetch_hit = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag) &&
                     (pid_mem[fetch_idx] == Pid_i) && (tid_mem[fetch_idx] == Tid_i);

  // Word 0 of a line sits in its MSBs, matching slot 0 of the bundle.
  logic [cacheLineWith-1:0]    line_rd;
  logic [instructionWidth-1:0] line_words [wordsPerLine];
  logic [instructionWidth-1:0] slot_data  [bundleSlots];
  logic [wordBits:0]           slot_idx   [bundleSlots];
  assign line_rd = data_mem[fetch_idx];

  for (genvar w = 0; w < wordsPerLine; w++) begin : g_words
    assign line_words[w] = line_rd[cacheLineWith-1-w*instructionWidth -: instructionWidth];
  end

  for (genvar s = 0; s < bundleSlots; s++) begin : g_slots
    assign slot_idx[s]  = {1'b0, fetch_word} + (wordBits+1)'(s);
    assign slot_data[s] = slot_idx[s][wordBits] ? '0 : line_words[slot_idx[s][wordBits-1:0]];
  end

  logic [4*instructionWidth-1:0] bundle_d;
  logic [wordBits:0]             words_left;
  logic [2:0]                    n_words;
  assign bundle_d   = {slot_data[0], slot_data[1], slot_data[2], slot_data[3]};
  assign words_left = (wordBits+1)'(wordsPerLine) - {1'b0, fetch_word};
  assign n_words    = (words_left >= (wordBits+1)'(bundleSlots)) ? 3'd4 : words_left[2:0];

  always_comb begin
    state_d = state_q;
    if (cacheReset_i || cacheUpdate_i) state_d = IDLE;
    else if (do_lookup && !fetch_hit)  state_d = MISS_PENDING;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign dbgState_o = state_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
    end else if (cacheReset_i) begin
      valid_q <= '0;
    end else begin
      if (naturalWriteEn_i) valid_q[nat_idx] <= 1'b1;
      if (cacheUpdate_i)    valid_q[upd_idx] <= 1'b1;
    end
  end

  // Refill is written second so it wins when both writes share an index.
  always_ff @(posedge clock_i) begin
    if (!cacheReset_i) begin
      if (naturalWriteEn_i) begin
        data_mem[nat_idx] <= naturalWriteLine_i;
        tag_mem[nat_idx]  <= nat_tag;
        pid_mem[nat_idx]  <= naturalPid_i;
        tid_mem[nat_idx]  <= naturalTid_i;
      end
      if (cacheUpdate_i) begin
        data_mem[upd_idx] <= cacheUpdateLine_i;
        tag_mem[upd_idx]  <= upd_tag;
        pid_mem[upd_idx]  <= cacheUpdatePid_i;
        tid_mem[upd_idx]  <= cacheUpdateTid_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      maj_q <= '0;
    end else if (!cacheReset_i && cacheUpdate_i) begin
      maj_q <= missedInstMajorId_i;
    end else if (do_lookup && fetch_hit) begin
      maj_q <= maj_q + {{(instructionCounterWidth-3){1'b0}}, n_words};
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      icachePCIncEnable_o <= 1'b0;
      iCachePCIncVal_o    <= '0;
      outputEnable_o      <= 1'b0;
      outputBundle_o      <= '0;
      bundleAddress_o     <= '0;
      bundleLen_o         <= '0;
      bundlePid_o         <= '0;
      bundleTid_o         <= '0;
      bundleStartMajId_o  <= '0;
      cacheMiss_o         <= 1'b0;
      missedAddress_o     <= '0;
      missedInstMajorId_o <= '0;
      missedPid_o         <= '0;
      missedTid_o         <= '0;
    end else begin
      outputEnable_o      <= 1'b0;
      cacheMiss_o         <= 1'b0;
      icachePCIncEnable_o <= 1'b0;
      if (do_lookup && fetch_hit) begin
        outputEnable_o      <= 1'b1;
        outputBundle_o      <= bundle_d;
        bundleAddress_o     <= fetchAddress_i;
        bundleLen_o         <= 2'(n_words - 3'd1);
        bundlePid_o         <= Pid_i;
        bundleTid_o         <= Tid_i;
        bundleStartMajId_o  <= maj_q;
        icachePCIncEnable_o <= (n_words != 3'd4);
        iCachePCIncVal_o    <= (n_words != 3'd4) ? n_words : 3'd0;
      end else if (do_lookup) begin
        cacheMiss_o         <= 1'b1;
        missedAddress_o     <= fetchAddress_i;
        missedInstMajorId_o <= maj_q;
        missedPid_o         <= Pid_i;
        missedTid_o         <= Tid_i;
      end
    end
  end

endmodule

// File: tb/tb_l1_inst_cache.sv
// Directed bench for l1_inst_cache: expected bundles/misses are queued when a
// fetch is driven and popped by a negedge monitor when the cache responds.
module tb_l1_inst_cache;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         fetchEnable_i = 1'b0, cacheReset_i = 1'b0, fetchStall_i = 1'b0;
  logic [19:0]  Pid_i = '0;
  logic [15:0]  Tid_i = '0;
  logic [63:0]  fetchAddress_i = '0;
  logic         cacheUpdate_i = 1'b0;
  logic [63:0]  cacheUpdateAddress_i = '0;
  logic [19:0]  cacheUpdatePid_i = '0;
  logic [15:0]  cacheUpdateTid_i = '0;
  logic [63:0]  missedInstMajorId_i = '0;
  logic [511:0] cacheUpdateLine_i = '0;
  logic         naturalWriteEn_i = 1'b0;
  logic [63:0]  naturalWriteAddress_i = '0;
  logic [511:0] naturalWriteLine_i = '0;
  logic [19:0]  naturalPid_i = '0;
  logic [15:0]  naturalTid_i = '0;
  logic         icachePCIncEnable_o;
  logic [2:0]   iCachePCIncVal_o;
  logic         outputEnable_o;
  logic [127:0] outputBundle_o;
  logic [63:0]  bundleAddress_o;
  logic [1:0]   bundleLen_o;
  logic [19:0]  bundlePid_o;
  logic [15:0]  bundleTid_o;
  logic [63:0]  bundleStartMajId_o;
  logic         cacheMiss_o;
  logic [63:0]  missedAddress_o;
  logic [63:0]  missedInstMajorId_o;
  logic [19:0]  missedPid_o;
  logic [15:0]  missedTid_o;
  logic         dbgState_o;

  l1_inst_cache dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetchEnable_i(fetchEnable_i),
    .cacheReset_i(cacheReset_i), .fetchStall_i(fetchStall_i), .Pid_i(Pid_i), .Tid_i(Tid_i),
    .fetchAddress_i(fetchAddress_i), .cacheUpdate_i(cacheUpdate_i),
    .cacheUpdateAddress_i(cacheUpdateAddress_i), .cacheUpdatePid_i(cacheUpdatePid_i),
    .cacheUpdateTid_i(cacheUpdateTid_i), .missedInstMajorId_i(missedInstMajorId_i),
    .cacheUpdateLine_i(cacheUpdateLine_i), .naturalWriteEn_i(naturalWriteEn_i),
    .naturalWriteAddress_i(naturalWriteAddress_i), .naturalWriteLine_i(naturalWriteLine_i),
    .naturalPid_i(naturalPid_i), .naturalTid_i(naturalTid_i),
    .icachePCIncEnable_o(icachePCIncEnable_o), .iCachePCIncVal_o(iCachePCIncVal_o),
    .outputEnable_o(outputEnable_o), .outputBundle_o(outputBundle_o),
    .bundleAddress_o(bundleAddress_o), .bundleLen_o(bundleLen_o),
    .bundlePid_o(bundlePid_o), .bundleTid_o(bundleTid_o),
    .bundleStartMajId_o(bundleStartMajId_o), .cacheMiss_o(cacheMiss_o),
    .missedAddress_o(missedAddress_o), .missedInstMajorId_o(missedInstMajorId_o),
    .missedPid_o(missedPid_o), .missedTid_o(missedTid_o), .dbgState_o(dbgState_o)
  );

  // Clock and reset
  always #5 clock_i = ~clock_i;

  // Scoreboard
  typedef struct packed {
    logic         is_miss;
    logic [63:0]  addr;
    logic [19:0]  pid;
    logic [15:0]  tid;
    logic [63:0]  maj;
    logic [127:0] bundle;
    logic [1:0]   len;
    logic         pcen;
    logic [2:0]   pcval;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] cnt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input int base);
    logic [511:0] l = '0;
    for (int i = 0; i < 16; i++) l = {l[479:0], 32'(base + i)};
    return l;
  endfunction

  function automatic logic [127:0] exp_bundle(input logic [511:0] line, input int w);
    logic [127:0] b = '0;
    logic [511:0] sh;
    for (int s = 0; s < 4; s++) begin
      if (w + s < 16) begin
        sh = line >> (32 * (15 - (w + s)));
        b  = b | (128'(sh[31:0]) << (32 * (3 - s)));
      end
    end
    return b;
  endfunction

  task automatic push_hit(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t,
                          input logic [511:0] line);
    exp_t e;
    int w = int'(a[5:2]);
    int nn = (16 - w < 4) ? 16 - w : 4;
    e = '0;
    e.addr = a; e.pid = p; e.tid = t; e.maj = cnt;
    e.bundle = exp_bundle(line, w);
    e.len = 2'(nn - 1);
    e.pcen = (nn < 4);
    e.pcval = (nn < 4) ? 3'(nn) : 3'd0;
    cnt = cnt + 64'(nn);
    exp_q.push_back(e);
  endtask

  task automatic push_miss(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t);
    exp_t e;
    e = '0;
    e.is_miss = 1'b1; e.addr = a; e.pid = p; e.tid = t; e.maj = cnt;
    exp_q.push_back(e);
  endtask

  // Driver tasks
  task automatic fetch(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t);
    fetchAddress_i = a; Pid_i = p; Tid_i = t; fetchEnable_i = 1'b1;
    @(posedge clock_i); #1;
    fetchEnable_i = 1'b0;
  endtask

  task automatic refill(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t,
                        input logic [511:0] line, input logic [63:0] maj);
    cacheUpdateAddress_i = a; cacheUpdatePid_i = p; cacheUpdateTid_i = t;
    cacheUpdateLine_i = line; missedInstMajorId_i = maj; cacheUpdate_i = 1'b1;
    cnt = maj;
    @(posedge clock_i); #1;
    cacheUpdate_i = 1'b0;
  endtask

  task automatic set_natural(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t,
                             input logic [511:0] line);
    naturalWriteAddress_i = a; naturalPid_i = p; naturalTid_i = t;
    naturalWriteLine_i = line; naturalWriteEn_i = 1'b1;
  endtask

  // Monitor: every pulse must match the head of the expected queue
  bit mon_en = 1'b0;
  always @(negedge clock_i) begin
    exp_t e;
    if (mon_en && (outputEnable_o || cacheMiss_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 128'({outputEnable_o, cacheMiss_o}), 128'(0));
      end else begin
        e = exp_q.pop_front();
        if (e.is_miss) begin
          chk("miss_pulse", 128'({outputEnable_o, cacheMiss_o}), 128'(2'b01));
          chk("miss_addr", 128'(missedAddress_o), 128'(e.addr));
          chk("miss_maj", 128'(missedInstMajorId_o), 128'(e.maj));
          chk("miss_ids", 128'({missedPid_o, missedTid_o}), 128'({e.pid, e.tid}));
        end else begin
          chk("hit_pulse", 128'({outputEnable_o, cacheMiss_o}), 128'(2'b10));
          chk("hit_bundle", outputBundle_o, e.bundle);
          chk("hit_addr", 128'(bundleAddress_o), 128'(e.addr));
          chk("hit_len", 128'(bundleLen_o), 128'(e.len));
          chk("hit_maj", 128'(bundleStartMajId_o), 128'(e.maj));
          chk("hit_ids", 128'({bundlePid_o, bundleTid_o}), 128'({e.pid, e.tid}));
          chk("hit_pcinc", 128'({icachePCIncEnable_o, iCachePCIncVal_o}), 128'({e.pcen, e.pcval}));
        end
      end
    end
  end

  logic [511:0] l0, l1, l2, l3;

  initial begin
    l0 = mk_line(32'h100); l1 = mk_line(32'h200);
    l2 = mk_line(32'h300); l3 = mk_line(32'h400);

    #2 reset_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_pulses", 128'({outputEnable_o, cacheMiss_o, icachePCIncEnable_o}), 128'(0));
    chk("rst_bundle", outputBundle_o, 128'(0));
    chk("rst_data", 128'({bundleAddress_o, bundleStartMajId_o}), 128'(0));
    chk("rst_miss_data", 128'({missedAddress_o, missedInstMajorId_o}), 128'(0));
    chk("rst_state", 128'(dbgState_o), 128'(0));
    reset_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clock_i); #1;

    push_miss(64'h0, 20'd0, 16'd0);
    fetch(64'h0, 20'd0, 16'd0);
    @(posedge clock_i); #1;
    chk("state_after_miss", 128'(dbgState_o), 128'(1));

    refill(64'h0, 20'd0, 16'd0, l0, 64'd0);
    chk("state_after_refill", 128'(dbgState_o), 128'(0));
    push_hit(64'h0,  20'd0, 16'd0, l0); fetch(64'h0,  20'd0, 16'd0);
    push_hit(64'h10, 20'd0, 16'd0, l0); fetch(64'h10, 20'd0, 16'd0);
    push_hit(64'h38, 20'd0, 16'd0, l0); fetch(64'h38, 20'd0, 16'd0);
    push_hit(64'h34, 20'd0, 16'd0, l0); fetch(64'h34, 20'd0, 16'd0);
    push_hit(64'h3C, 20'd0, 16'd0, l0); fetch(64'h3C, 20'd0, 16'd0);

    fetchStall_i = 1'b1;
    fetch(64'h0, 20'd0, 16'd0);
    fetchStall_i = 1'b0;

    push_miss(64'h0, 20'd5, 16'd0);
    fetch(64'h0, 20'd5, 16'd0);
    for (int i = 0; i < 3; i++) fetch(64'h0, 20'd0, 16'd0);
    refill(64'h0, 20'd5, 16'd0, l0, 64'd100);
    push_hit(64'h0, 20'd5, 16'd0, l0); fetch(64'h0, 20'd5, 16'd0);

    set_natural(64'h4000, 20'd0, 16'd0, l1);
    @(posedge clock_i); #1;
    naturalWriteEn_i = 1'b0;
    push_hit(64'h4000, 20'd0, 16'd0, l1); fetch(64'h4000, 20'd0, 16'd0);

    push_miss(64'h4000, 20'd0, 16'd3);
    fetch(64'h4000, 20'd0, 16'd3);
    refill(64'h4000, 20'd0, 16'd3, l1, cnt);

    // Lookup and natural write to the same index: lookup sees the old line
    set_natural(64'h4000, 20'd0, 16'd3, l2);
    push_hit(64'h4000, 20'd0, 16'd3, l1); fetch(64'h4000, 20'd0, 16'd3);
    naturalWriteEn_i = 1'b0;
    push_hit(64'h4008, 20'd0, 16'd3, l2); fetch(64'h4008, 20'd0, 16'd3);

    // Invalidate-all suppresses the same-cycle fetch and keeps the counter
    cacheReset_i = 1'b1;
    fetch(64'h4000, 20'd0, 16'd3);
    cacheReset_i = 1'b0;
    push_miss(64'h4000, 20'd0, 16'd3);
    fetch(64'h4000, 20'd0, 16'd3);

    // Refill and natural write on one index: refill wins
    set_natural(64'h0, 20'd0, 16'd0, l3);
    refill(64'h4000, 20'd0, 16'd3, l2, cnt);
    naturalWriteEn_i = 1'b0;
    push_hit(64'h4000, 20'd0, 16'd3, l2); fetch(64'h4000, 20'd0, 16'd3);

    // Asynchronous reset while a hit is on the outputs
    fetch(64'h4004, 20'd0, 16'd3);
    chk("pre_reset_hit", 128'(outputEnable_o), 128'(1));
    #1 reset_i = 1'b0;
    #1;
    chk("async_rst_pulses", 128'({outputEnable_o, cacheMiss_o, icachePCIncEnable_o}), 128'(0));
    chk("async_rst_bundle", outputBundle_o, 128'(0));
    chk("async_rst_data", 128'({bundleAddress_o, bundleStartMajId_o, bundleLen_o}), 128'(0));
    chk("async_rst_ids", 128'({bundlePid_o, bundleTid_o, iCachePCIncVal_o}), 128'(0));
    repeat (2) @(posedge clock_i);
    reset_i = 1'b1;
    repeat (2) @(posedge clock_i);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
